// File: rtl/leiwand_rv32_wb_ram.sv
// ---------------------------------------------------------------------------
// leiwand_rv32_wb_ram
//
// Wishbone B4 pipelined slave in front of a word-addressed synchronous RAM.
// It answers the core's instruction fetches and data accesses. Only one
// transaction is outstanding at a time. A programmable number of wait
// states sits between accepting a request and acknowledging it.
//
// Parameters
//   MEM_WIDTH    data and address width in bits
//   BASE_ADDR    byte address of RAM word 0
//   DEPTH_WORDS  number of MEM_WIDTH-bit words
//   WAIT_STATES  extra cycles between accept and ack (0..15)
//   INIT_FILE    preload image name; contents start X
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active-high
//   i_cyc    wishbone cycle valid
//   i_stb    wishbone strobe (request)
//   i_we     1 = write, 0 = read
//   i_addr   byte address
//   i_data   write data
//   o_ack    one-cycle transaction acknowledge
//   o_stall  slave cannot take a request this cycle
//   o_data   read data, valid with o_ack, zero otherwise
//   o_err    pulses with o_ack for an out-of-range address
// ---------------------------------------------------------------------------
module leiwand_rv32_wb_ram #(
    parameter int unsigned          MEM_WIDTH   = 32,
    parameter logic [MEM_WIDTH-1:0] BASE_ADDR   = 32'h10000000,
    parameter int unsigned          DEPTH_WORDS = 1024,
    parameter int unsigned          WAIT_STATES = 0,
    parameter string                INIT_FILE   = ""
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cyc,
    input  logic                 i_stb,
    input  logic                 i_we,
    input  logic [MEM_WIDTH-1:0] i_addr,
    input  logic [MEM_WIDTH-1:0] i_data,
    output logic                 o_ack,
    output logic                 o_stall,
    output logic [MEM_WIDTH-1:0] o_data,
    output logic                 o_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [MEM_WIDTH-1:0] SPAN = MEM_WIDTH'(DEPTH_WORDS) << 2;
    localparam bit         WS_ZERO = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = WS_ZERO ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [MEM_WIDTH-1:0] mem [DEPTH_WORDS];

    // Request captured at accept, consumed when the wait states run out.
    logic                 req_we_p0;
    logic [MEM_WIDTH-1:0] req_addr_p0;
    logic [MEM_WIDTH-1:0] req_data_p0;

    logic                 accept;
    logic                 enter_ack;
    logic                 txn_we;
    logic [MEM_WIDTH-1:0] txn_addr;
    logic [MEM_WIDTH-1:0] txn_data;
    logic [MEM_WIDTH-1:0] txn_off;
    logic                 txn_in_range;
    logic [IDX_W-1:0]     txn_idx;

    assign o_stall = (state_q == S_WAIT);
    assign accept  = i_cyc && i_stb && !o_stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ACK: begin
                if (accept) begin
                    if (WS_ZERO) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Dropping the cycle abandons the request before anything commits.
                if (!i_cyc) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The edge that moves into ACK is the one that reads or writes the RAM.
    // With no wait states that edge is also the accept edge, so the request
    // is taken straight from the bus instead of from the capture registers.
    assign enter_ack = (state_d == S_ACK) && !i_rst;

    always_comb begin
        txn_we   = i_we;
        txn_addr = i_addr;
        txn_data = i_data;
        if (state_q == S_WAIT) begin
            txn_we   = req_we_p0;
            txn_addr = req_addr_p0;
            txn_data = req_data_p0;
        end
    end

    // Offset compare covers both bounds: addresses below BASE_ADDR wrap to a
    // large offset. addr[1:0] never reach the index.
    assign txn_off      = txn_addr - BASE_ADDR;
    assign txn_in_range = (txn_off < SPAN);
    assign txn_idx      = txn_off[IDX_W+1:2];

    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_we_p0   <= i_we;
            req_addr_p0 <= i_addr;
            req_data_p0 <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (enter_ack && txn_we && txn_in_range) begin
            mem[txn_idx] <= txn_data;
        end
    end

    // Response stage: ack, error flag and read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            o_ack   <= 1'b0;
            o_err   <= 1'b0;
            o_data  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_ack   <= enter_ack;
            o_err   <= enter_ack && !txn_in_range;
            o_data  <= (enter_ack && !txn_we && txn_in_range) ? mem[txn_idx] : '0;
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_wb_ram.sv
module tb_leiwand_rv32_wb_ram;

    logic        clk;
    logic        rst;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic        ack  [2];
    logic        stall[2];
    logic        err  [2];
    logic [31:0] rdat [2];

    int n_checks = 0;
    int n_errors = 0;

    leiwand_rv32_wb_ram #(.WAIT_STATES(0)) dut_ws0 (
        .i_clk(clk), .i_rst(rst), .i_cyc(cyc[0]), .i_stb(stb[0]), .i_we(we[0]),
        .i_addr(adr[0]), .i_data(wdat[0]), .o_ack(ack[0]), .o_stall(stall[0]),
        .o_data(rdat[0]), .o_err(err[0])
    );

    leiwand_rv32_wb_ram #(.WAIT_STATES(3)) dut_ws3 (
        .i_clk(clk), .i_rst(rst), .i_cyc(cyc[1]), .i_stb(stb[1]), .i_we(we[1]),
        .i_addr(adr[1]), .i_data(wdat[1]), .o_ack(ack[1]), .o_stall(stall[1]),
        .o_data(rdat[1]), .o_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // One transaction on slave s; observes a fixed window after the accept edge.
    task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat,
                       output int nack, output int nstall, output logic st_at_ack);
        cyc[s] = 1'b1; stb[s] = 1'b1; we[s] = w; adr[s] = a; wdat[s] = d;
        @(posedge clk); #1;
        stb[s] = 1'b0;
        rd = '0; e = 1'b0; lat = 0; nack = 0; nstall = 0; st_at_ack = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (ack[s]) begin
                nack++;
                if (nack == 1) begin
                    lat = k; rd = rdat[s]; e = err[s]; st_at_ack = stall[s];
                end
            end
            if (stall[s]) nstall++;
            @(posedge clk); #1;
        end
        cyc[s] = 1'b0; we[s] = 1'b0;
    endtask

    task automatic do_access(input string tag, input int s, input int ws, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        e, sa;
        int          lat, nack, nstall;
        txn(s, w, a, d, rd, e, lat, nack, nstall, sa);
        chk({tag, "_nack"},   32'(nack),   32'd1);
        chk({tag, "_lat"},    32'(lat),    32'(ws + 1));
        chk({tag, "_stalls"}, 32'(nstall), 32'(ws));
        chk({tag, "_stall_at_ack"}, 32'(sa), 32'd0);
        chk({tag, "_err"},    32'(e),      32'(exp_err));
        chk({tag, "_data"},   rd,          exp_data);
    endtask

    task automatic back_to_back(input string tag, input int s, input int ws);
        int          n, t1, t2;
        logic [31:0] d1, d2;
        n = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        cyc[s] = 1'b1; stb[s] = 1'b1; we[s] = 1'b0; adr[s] = 32'h10000008;
        @(posedge clk); #1;
        adr[s] = 32'h10000004;
        for (int k = 1; k <= 20; k++) begin
            if (ack[s]) begin
                n++;
                if (n == 1) begin t1 = k; d1 = rdat[s]; end
                else if (n == 2) begin t2 = k; d2 = rdat[s]; end
            end
            @(posedge clk); #1;
            if (n >= 1) stb[s] = 1'b0;
        end
        cyc[s] = 1'b0;
        chk({tag, "_nack"}, 32'(n),  32'd2);
        chk({tag, "_t1"},   32'(t1), 32'(ws + 1));
        chk({tag, "_t2"},   32'(t2), 32'(2 * (ws + 1)));
        chk({tag, "_d1"},   d1,      32'hDEADBEEF);
        chk({tag, "_d2"},   d2,      32'h11112222);
    endtask

    task automatic count_acks(input int s, input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (ack[s]) n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0; adr[s] = '0; wdat[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0",   32'(ack[0]),   32'd0);
        chk("rst_stall0", 32'(stall[0]), 32'd0);
        chk("rst_data0",  rdat[0],       32'd0);
        chk("rst_err0",   32'(err[0]),   32'd0);
        chk("rst_ack3",   32'(ack[1]),   32'd0);
        chk("rst_stall3", 32'(stall[1]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero wait states: preload word 0 by a bus write, then read it back.
        do_access("ws0_wr_w0",  0, 0, 1'b1, 32'h10000000, 32'h00500093, 32'h0, 1'b0);
        do_access("ws0_rd_w0",  0, 0, 1'b0, 32'h10000000, 32'h0, 32'h00500093, 1'b0);
        do_access("ws0_wr_w2",  0, 0, 1'b1, 32'h10000008, 32'hDEADBEEF, 32'h0, 1'b0);
        do_access("ws0_rd_w2",  0, 0, 1'b0, 32'h10000008, 32'h0, 32'hDEADBEEF, 1'b0);
        do_access("ws0_rd_mis", 0, 0, 1'b0, 32'h1000000A, 32'h0, 32'hDEADBEEF, 1'b0);
        do_access("ws0_wr_w1",  0, 0, 1'b1, 32'h10000004, 32'h11112222, 32'h0, 1'b0);
        back_to_back("ws0_b2b", 0, 0);

        // Strobe without a cycle is not a request.
        stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10000000; wdat[0] = 32'hFFFFFFFF;
        count_acks(0, 4, n);
        stb[0] = 1'b0; we[0] = 1'b0;
        chk("stb_no_cyc_acks", 32'(n), 32'd0);

        // Out of range on both sides of the window.
        do_access("ws0_wr_top", 0, 0, 1'b1, 32'h10000FFC, 32'hCAFEF00D, 32'h0, 1'b0);
        do_access("oor_wr",     0, 0, 1'b1, 32'h0FFFFFFC, 32'h12345678, 32'h0, 1'b1);
        do_access("oor_rd",     0, 0, 1'b0, 32'h10001000, 32'h0, 32'h0, 1'b1);
        do_access("oor_w0",     0, 0, 1'b0, 32'h10000000, 32'h0, 32'h00500093, 1'b0);
        do_access("oor_w1023",  0, 0, 1'b0, 32'h10000FFC, 32'h0, 32'hCAFEF00D, 1'b0);

        // Three wait states.
        do_access("ws3_wr_w0", 1, 3, 1'b1, 32'h10000000, 32'h00500093, 32'h0, 1'b0);
        do_access("ws3_rd_w0", 1, 3, 1'b0, 32'h10000000, 32'h0, 32'h00500093, 1'b0);
        do_access("ws3_wr_w1", 1, 3, 1'b1, 32'h10000004, 32'h11112222, 32'h0, 1'b0);
        do_access("ws3_wr_w2", 1, 3, 1'b1, 32'h10000008, 32'hDEADBEEF, 32'h0, 1'b0);
        back_to_back("ws3_b2b", 1, 3);
        do_access("ws3_wr_w4", 1, 3, 1'b1, 32'h10000010, 32'h00000044, 32'h0, 1'b0);

        // Abort by dropping the cycle during WAIT.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h10000010; wdat[1] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        stb[1] = 1'b0;
        chk("abort_stall_wait", 32'(stall[1]), 32'd1);
        @(posedge clk); #1;
        cyc[1] = 1'b0;
        @(posedge clk); #1;
        chk("abort_stall_after", 32'(stall[1]), 32'd0);
        count_acks(1, 8, n);
        chk("abort_acks", 32'(n), 32'd0);
        we[1] = 1'b0;
        do_access("abort_w4", 1, 3, 1'b0, 32'h10000010, 32'h0, 32'h00000044, 1'b0);

        // Reset in the middle of WAIT.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h10000010; wdat[1] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        stb[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_ack",   32'(ack[1]),   32'd0);
        chk("rstmid_stall", 32'(stall[1]), 32'd0);
        chk("rstmid_data",  rdat[1],       32'd0);
        chk("rstmid_err",   32'(err[1]),   32'd0);
        rst = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
        count_acks(1, 8, n);
        chk("rstmid_acks", 32'(n), 32'd0);
        do_access("rstmid_w4", 1, 3, 1'b0, 32'h10000010, 32'h0, 32'h00000044, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
